// File: rtl/datamem_ctrl.sv
// datamem_ctrl: word-addressed synchronous data memory with a valid/ready
// request port, byte-enable writes, one-cycle registered responses,
// out-of-range error reporting and a one-word-per-cycle clear sweep.
module datamem_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 1024,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_be,
    input  logic                    clear,
    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    busy
);

    localparam int unsigned BE_W  = DATA_WIDTH / 8;
    localparam int unsigned IDX_W = $clog2(DEPTH);

    if (DATA_WIDTH < 8 || (DATA_WIDTH % 8) != 0) begin : g_bad_width
        $error("datamem_ctrl: DATA_WIDTH must be a multiple of 8 and at least 8");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("datamem_ctrl: DEPTH must be a power of two and at least 2");
    end
    if (ADDR_WIDTH < IDX_W) begin : g_bad_addr
        $error("datamem_ctrl: ADDR_WIDTH too narrow to address DEPTH words");
    end

    typedef enum logic {
        ST_SWEEP,
        ST_IDLE
    } state_t;

    state_t           state, state_nx;
    logic [IDX_W-1:0] sweep_idx, sweep_idx_nx;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic             accept;
    logic             in_range;
    logic [IDX_W-1:0] idx;

    assign idx = req_addr[IDX_W-1:0];

    // DEPTH is a power of two, so in-range means all address bits above the index are zero
    if (ADDR_WIDTH > IDX_W) begin : g_range
        assign in_range = (req_addr[ADDR_WIDTH-1:IDX_W] == '0);
    end else begin : g_full
        assign in_range = 1'b1;
    end

    // State and sweep counter; reset restarts the sweep from word 0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_SWEEP;
            sweep_idx <= '0;
        end else begin
            state     <= state_nx;
            sweep_idx <= sweep_idx_nx;
        end
    end

    // Next-state, sweep advance and handshake outputs
    always_comb begin
        state_nx     = state;
        sweep_idx_nx = sweep_idx;
        busy         = 1'b0;
        req_ready    = 1'b0;
        unique case (state)
            ST_SWEEP: begin
                busy         = 1'b1;
                sweep_idx_nx = sweep_idx + 1'b1;
                if (sweep_idx == IDX_W'(DEPTH - 1)) begin
                    state_nx     = ST_IDLE;
                    sweep_idx_nx = '0;
                end
            end
            ST_IDLE: begin
                req_ready = !clear;
                if (clear) begin
                    state_nx     = ST_SWEEP;
                    sweep_idx_nx = '0;
                end
            end
            default: begin
                state_nx     = ST_SWEEP;
                sweep_idx_nx = '0;
            end
        endcase
    end

    assign accept = req_valid && req_ready;

    // Array writes: sweep zeroing, or byte-enabled in-range request writes.
    // Sweep writes are held off while reset is asserted so reset never touches the array.
    always_ff @(posedge clk) begin
        if (state == ST_SWEEP) begin
            if (!reset) begin
                mem[sweep_idx] <= '0;
            end
        end else if (accept && req_write && in_range) begin
            for (int unsigned i = 0; i < BE_W; i++) begin
                if (req_be[i]) begin
                    mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
                end
            end
        end
    end

    // One-cycle response registers; read data reflects the array before this edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= accept;
            rsp_err   <= accept && !in_range;
            if (accept && !req_write && in_range) begin
                rsp_rdata <= mem[idx];
            end else begin
                rsp_rdata <= '0;
            end
        end
    end

endmodule

// File: tb/tb_datamem_ctrl.sv
// tb_datamem_ctrl: directed scoreboard bench for datamem_ctrl (DEPTH=16, 16-bit words).
module tb_datamem_ctrl;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  req_be;
    logic        clear;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    datamem_ctrl #(
        .DATA_WIDTH(16),
        .DEPTH(16),
        .ADDR_WIDTH(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .req_be(req_be),
        .clear(clear),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .busy(busy)
    );

    typedef struct {
        logic [15:0] rdata;
        logic        err;
        int          due;
        string       name;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: pops an expectation whenever a response is presented
    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rsp actual=rdata %0h err %0b required=no response", rsp_rdata, rsp_err);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk({e.name, "_rdata"}, 32'(rsp_rdata), 32'(e.rdata));
                chk({e.name, "_err"},   32'(rsp_err),   32'(e.err));
                chk({e.name, "_cycle"}, 32'(cyc),       32'(e.due));
            end
        end else begin
            chk("idle_rsp_zero", {15'b0, rsp_err, rsp_rdata}, 32'h0);
        end
    end

    task automatic issue(input string name, input logic wr, input logic [15:0] addr,
                         input logic [15:0] wdata, input logic [1:0] be,
                         input logic [15:0] exp_rdata, input logic exp_err);
        exp_t e;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        #1;
        chk({name, "_ready"}, 32'(req_ready), 32'h1);
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.due   = cyc + 1;
        e.name  = name;
        q.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        req_valid = 1'b0;
        req_write = 1'b0;
        clear     = 1'b0;
    endtask

    // Called at a negedge; counts negedge samples with busy high (bounded)
    task automatic wait_sweep(input string name);
        int   n = 0;
        logic rdy_bad = 1'b0;
        while (busy === 1'b1 && n < 100) begin
            if (req_ready !== 1'b0) rdy_bad = 1'b1;
            n++;
            @(negedge clk);
        end
        chk({name, "_sweep_len"}, 32'(n), 32'd16);
        chk({name, "_ready_low"}, 32'(rdy_bad), 32'h0);
        chk({name, "_ready_after"}, 32'(req_ready), 32'h1);
    endtask

    task automatic chk_reset_vals(input string name);
        chk({name, "_ready"}, 32'(req_ready), 32'h0);
        chk({name, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
        chk({name, "_rdata"}, 32'(rsp_rdata), 32'h0);
        chk({name, "_err"}, 32'(rsp_err), 32'h0);
        chk({name, "_busy"}, 32'(busy), 32'h1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
        clear     = 1'b0;

        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        reset = 1'b0;
        wait_sweep("init");

        for (int i = 0; i < 16; i++) issue("rd_init", 1'b0, 16'(i), 16'h0, 2'b00, 16'h0000, 1'b0);

        issue("wr_full",   1'b1, 16'd5, 16'hABCD, 2'b11, 16'h0000, 1'b0);
        issue("wr_hi",     1'b1, 16'd5, 16'h1200, 2'b10, 16'h0000, 1'b0);
        issue("rd_be",     1'b0, 16'd5, 16'h0000, 2'b00, 16'h12CD, 1'b0);
        issue("wr_lo",     1'b1, 16'd6, 16'h3456, 2'b01, 16'h0000, 1'b0);
        issue("rd_lo",     1'b0, 16'd6, 16'h0000, 2'b00, 16'h0056, 1'b0);
        issue("wr_nobe",   1'b1, 16'd5, 16'hFFFF, 2'b00, 16'h0000, 1'b0);
        issue("rd_nobe",   1'b0, 16'd5, 16'h0000, 2'b00, 16'h12CD, 1'b0);
        issue("wr_b2b",    1'b1, 16'd3, 16'h00FF, 2'b11, 16'h0000, 1'b0);
        issue("rd_b2b",    1'b0, 16'd3, 16'h0000, 2'b00, 16'h00FF, 1'b0);
        issue("wr_oor",    1'b1, 16'd16, 16'hFFFF, 2'b11, 16'h0000, 1'b1);
        issue("rd_alias0", 1'b0, 16'd0, 16'h0000, 2'b00, 16'h0000, 1'b0);
        issue("rd_oor",    1'b0, 16'd16, 16'h0000, 2'b00, 16'h0000, 1'b1);
        issue("rd_oor_max", 1'b0, 16'hFFFF, 16'h0000, 2'b00, 16'h0000, 1'b1);
        issue("rd_top",    1'b0, 16'd15, 16'h0000, 2'b00, 16'h0000, 1'b0);
        idle();

        // Clear collides with a read: clear wins, no response
        @(negedge clk);
        clear     = 1'b1;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 16'd3;
        #1;
        chk("clear_collision_ready", 32'(req_ready), 32'h0);
        @(negedge clk);
        clear     = 1'b0;
        req_valid = 1'b0;
        wait_sweep("clear");
        for (int i = 0; i < 16; i++) issue("rd_cleared", 1'b0, 16'(i), 16'h0, 2'b00, 16'h0000, 1'b0);
        issue("wr_pre", 1'b1, 16'd9, 16'h5A5A, 2'b11, 16'h0000, 1'b0);
        idle();

        // Reset while a response is pending drops it
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 16'd9;
        #1;
        chk("drop_ready", 32'(req_ready), 32'h1);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk_reset_vals("drop");
        @(negedge clk);
        req_valid = 1'b0;
        reset     = 1'b0;

        // Reset at sweep index 7 restarts a full sweep
        repeat (7) @(negedge clk);
        chk("mid_busy_before", 32'(busy), 32'h1);
        reset = 1'b1;
        #1;
        chk_reset_vals("mid");
        @(negedge clk);
        reset = 1'b0;
        wait_sweep("restart");
        issue("rd_after_restart9", 1'b0, 16'd9, 16'h0, 2'b00, 16'h0000, 1'b0);
        issue("rd_after_restart15", 1'b0, 16'd15, 16'h0, 2'b00, 16'h0000, 1'b0);
        idle();
        repeat (2) @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
